// File: rtl/collision_detection.sv
// collision_detection
//
// Per-frame collision checker for the paddle/ball game datapath. Compares the
// ball centre against the paddle's vertical hitbox and against the floor line.
// It produces registered contact levels, one-cycle onset pulses and
// saturating onset counters.
//
// There is no handshake and no enable. Inputs are sampled on every rising
// clk edge, and every output updates one cycle after its inputs change.
//
// Ports:
//   clk                 system clock, all state on the rising edge
//   reset               synchronous, active-high; clears every output
//   paddleX, paddleY    paddle centre (unsigned pixels)
//   ballX, ballY        ball centre (unsigned pixels)
//   ballTouchingPaddle  registered paddle-contact level
//   ballTouchingFloor   registered floor-contact level
//   paddleHitPulse      high for the first cycle of paddle contact
//   floorHitPulse       high for the first cycle of floor contact
//   paddleHitCount      paddle-contact onsets, saturating at all-ones
//   floorHitCount       floor-contact onsets, saturating at all-ones
module collision_detection #(
  parameter int BIT_WIDTH     = 10,
  parameter int BALL_RADIUS   = 5,
  parameter int PADDLE_RADIUS = 20,
  parameter int FLOOR_Y       = 479,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BIT_WIDTH-1:0]   paddleX,
  input  logic [BIT_WIDTH-1:0]   paddleY,
  input  logic [BIT_WIDTH-1:0]   ballX,
  input  logic [BIT_WIDTH-1:0]   ballY,
  output logic                   ballTouchingPaddle,
  output logic                   ballTouchingFloor,
  output logic                   paddleHitPulse,
  output logic                   floorHitPulse,
  output logic [COUNT_WIDTH-1:0] paddleHitCount,
  output logic [COUNT_WIDTH-1:0] floorHitCount
);

  // All vertical arithmetic is done one bit wider than the coordinates.
  // This keeps the hitbox top and the floor comparison from ever wrapping.
  localparam int EW = BIT_WIDTH + 1;
  localparam logic [EW-1:0] PADDLE_R = EW'(PADDLE_RADIUS);
  localparam logic [EW-1:0] BALL_R   = EW'(BALL_RADIUS);
  localparam logic [EW-1:0] FLOOR_W  = EW'(FLOOR_Y);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [EW-1:0] ballYWide;
  logic [EW-1:0] paddleYWide;
  logic [EW-1:0] paddleHi;
  logic [EW-1:0] paddleLo;
  logic          paddleTerm;
  logic          floorTerm;

  always_comb begin
    ballYWide   = {1'b0, ballY};
    paddleYWide = {1'b0, paddleY};
    paddleHi    = paddleYWide + PADDLE_R;
    // Clamp the bottom of the hitbox at row 0 instead of letting it underflow.
    paddleLo    = (paddleYWide < PADDLE_R) ? '0 : (paddleYWide - PADDLE_R);
    paddleTerm  = (ballX == paddleX) && (ballYWide >= paddleLo) &&
                  (ballYWide <= paddleHi);
    // The range guard comes first, so the subtraction is only used when it
    // cannot go negative. A ball at rows 0..BALL_RADIUS-1 is never on the floor.
    floorTerm   = (ballYWide >= BALL_R) && ((ballYWide - BALL_R) == FLOOR_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ballTouchingPaddle <= 1'b0;
      ballTouchingFloor  <= 1'b0;
      paddleHitPulse     <= 1'b0;
      floorHitPulse      <= 1'b0;
      paddleHitCount     <= '0;
      floorHitCount      <= '0;
    end else begin
      ballTouchingPaddle <= paddleTerm;
      ballTouchingFloor  <= floorTerm;
      // An onset is a new contact while the registered level is still low.
      // The pulse therefore lines up with the first cycle the level is high.
      paddleHitPulse     <= paddleTerm && !ballTouchingPaddle;
      floorHitPulse      <= floorTerm && !ballTouchingFloor;
      if (paddleTerm && !ballTouchingPaddle && (paddleHitCount != COUNT_MAX))
        paddleHitCount <= paddleHitCount + 1'b1;
      if (floorTerm && !ballTouchingFloor && (floorHitCount != COUNT_MAX))
        floorHitCount <= floorHitCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_detection.sv
// Directed testbench for collision_detection. Every expected value below was
// worked out by hand from the default parameters:
//   paddle hitbox = paddleY-20 .. paddleY+20 (bottom clamped at 0)
//   floor contact = ballY == 484
module tb_collision_detection;

  logic       clk;
  logic       reset;
  logic [9:0] paddleX, paddleY, ballX, ballY;
  logic       ballTouchingPaddle, ballTouchingFloor;
  logic       paddleHitPulse, floorHitPulse;
  logic [7:0] paddleHitCount, floorHitCount;

  int checks = 0;
  int errors = 0;

  collision_detection dut (
    .clk                (clk),
    .reset              (reset),
    .paddleX            (paddleX),
    .paddleY            (paddleY),
    .ballX              (ballX),
    .ballY              (ballY),
    .ballTouchingPaddle (ballTouchingPaddle),
    .ballTouchingFloor  (ballTouchingFloor),
    .paddleHitPulse     (paddleHitPulse),
    .floorHitPulse      (floorHitPulse),
    .paddleHitCount     (paddleHitCount),
    .floorHitCount      (floorHitCount)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compares all six outputs against the expected values.
  // Argument order: paddle level, floor level, paddle pulse, floor pulse,
  // paddle count, floor count.
  task automatic checkAll(input string tag, input int tp, input int tf,
                          input int pp, input int pf, input int pc,
                          input int fc);
    checkVal({tag, ".paddleLevel"}, 32'(ballTouchingPaddle), tp);
    checkVal({tag, ".floorLevel"},  32'(ballTouchingFloor),  tf);
    checkVal({tag, ".paddlePulse"}, 32'(paddleHitPulse),     pp);
    checkVal({tag, ".floorPulse"},  32'(floorHitPulse),      pf);
    checkVal({tag, ".paddleCount"}, 32'(paddleHitCount),     pc);
    checkVal({tag, ".floorCount"},  32'(floorHitCount),      fc);
  endtask

  // ---------------- driver ----------------
  // Inputs are applied on the falling edge, one rising edge is taken, and the
  // outputs are sampled 1 ns after that edge.
  task automatic step(input int px, input int py, input int bx, input int by,
                      input logic rst);
    @(negedge clk);
    paddleX = 10'(px);
    paddleY = 10'(py);
    ballX   = 10'(bx);
    ballY   = 10'(by);
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int expCount;
    reset   = 1'b1;
    paddleX = '0;
    paddleY = '0;
    ballX   = '0;
    ballY   = '0;

    step(0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 1'b1);
    checkAll("reset", 0, 0, 0, 0, 0, 0);

    // No contact at all.
    step(50, 240, 100, 200, 1'b0);
    checkAll("idle", 0, 0, 0, 0, 0, 0);

    // Paddle contact held for three cycles: one pulse, one count.
    step(50, 240, 50, 240, 1'b0);
    checkAll("padCentre", 1, 0, 1, 0, 1, 0);
    step(50, 240, 50, 260, 1'b0);
    checkAll("padTopEdge", 1, 0, 0, 0, 1, 0);
    step(50, 240, 50, 220, 1'b0);
    checkAll("padBotEdge", 1, 0, 0, 0, 1, 0);

    // Near misses: wrong X, one row past the top, one row past the bottom.
    step(50, 240, 51, 240, 1'b0);
    checkAll("missX", 0, 0, 0, 0, 1, 0);
    step(50, 240, 50, 261, 1'b0);
    checkAll("missAbove", 0, 0, 0, 0, 1, 0);
    step(50, 240, 50, 219, 1'b0);
    checkAll("missBelow", 0, 0, 0, 0, 1, 0);

    // Touching again after the misses counts a second onset.
    step(50, 240, 50, 240, 1'b0);
    checkAll("padRetouch", 1, 0, 1, 0, 2, 0);

    // Floor contact is exactly row 484, regardless of ball X.
    step(50, 240, 200, 484, 1'b0);
    checkAll("floorHit", 0, 1, 0, 1, 2, 1);
    step(50, 240, 200, 484, 1'b0);
    checkAll("floorHold", 0, 1, 0, 0, 2, 1);
    step(50, 240, 200, 483, 1'b0);
    checkAll("floor483", 0, 0, 0, 0, 2, 1);
    step(50, 240, 200, 485, 1'b0);
    checkAll("floor485", 0, 0, 0, 0, 2, 1);

    // Bottom of the hitbox clamps at row 0 when paddleY is 5.
    step(50, 5, 50, 0, 1'b0);
    checkAll("clampLo", 1, 0, 1, 0, 3, 0 + 1);
    step(50, 5, 50, 26, 1'b0);
    checkAll("clampHiMiss", 0, 0, 0, 0, 3, 1);

    // A small ballY must not wrap into a floor match.
    step(50, 240, 200, 3, 1'b0);
    checkAll("floorNoWrap", 0, 0, 0, 0, 3, 1);

    // Paddle and floor contact at the same time.
    step(50, 480, 50, 484, 1'b0);
    checkAll("bothHit", 1, 1, 1, 1, 4, 2);

    // Reset while in contact clears everything.
    step(50, 480, 50, 484, 1'b1);
    checkAll("midReset", 0, 0, 0, 0, 0, 0);

    // Contact still present after release: fresh onsets, counts go to 1.
    step(50, 480, 50, 484, 1'b0);
    checkAll("postReset", 1, 1, 1, 1, 1, 1);

    // Saturation: 300 paddle onsets from a cleared state.
    step(50, 240, 51, 240, 1'b1);
    expCount = 0;
    for (int i = 1; i <= 300; i++) begin
      step(50, 240, 50, 240, 1'b0);
      step(50, 240, 51, 240, 1'b0);
      if (expCount < 255) expCount++;
      if (i == 254 || i == 255 || i == 256)
        checkVal($sformatf("satCount%0d", i), 32'(paddleHitCount), expCount);
    end
    checkVal("satFinal", 32'(paddleHitCount), 255);

    // Top of the hitbox near the coordinate ceiling must not wrap.
    // Here paddleY + 20 = 1040, so ballY = 1023 is inside the hitbox.
    step(50, 1020, 50, 1023, 1'b0);
    checkAll("hiNoWrap", 1, 0, 1, 0, 255, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
